// File: rtl/jk_excitation_gen.sv
// JK flip-flop stimulus driver and checker. Target Q bits are buffered in a FIFO and
// turned into J/K excitation codes. The DUT's Q feedback is checked LAT edges after each drive.
module jk_excitation_gen #(
  parameter int DEPTH = 4,
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             hold,
  input  logic             q_fb,
  input  logic             clr_err,
  output logic             j,
  output logic             k,
  output logic             drive_valid,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  // state  | meaning
  // IDLE   | FIFO empty, no checks pending
  // DRIVE  | FIFO holds targets still to be driven
  // DRAIN  | FIFO empty, checks still in flight
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             q_model_q, q_model_d;
  logic             j_q, j_d, k_q, k_d, dv_q, dv_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT-1:0]   pv_q, pv_d, pe_q, pe_d;

  logic empty, full, push, pop, pop_bit, mismatch, empty_nxt, pipe_nxt;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = tgt_valid && !full;
  assign pop      = !empty && !hold;
  assign pop_bit  = mem_q[rd_ptr_q[AW-1:0]];
  assign mismatch = pv_q[LAT-1] && (q_fb != pe_q[LAT-1]);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    q_model_d = q_model_q;
    cnt_d     = cnt_q;
    state_d   = state_q;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = tgt_bit;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      q_model_d = pop_bit;
    end

    // Don't-care halves of the excitation table are tied to 0.
    j_d  = pop && pop_bit && !q_model_q;
    k_d  = pop && !pop_bit && q_model_q;
    dv_d = pop;

    pv_d[0] = pop;
    pe_d[0] = pop_bit;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
    end

    err_d = mismatch;
    if (clr_err)
      cnt_d = '0;
    else if (mismatch && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;

    // Decide on next-cycle occupancy so busy drops on the edge that retires the last check.
    empty_nxt = (wr_ptr_d == rd_ptr_d);
    pipe_nxt  = |pv_d;
    case (state_q)
      S_IDLE:  if (!empty_nxt) state_d = S_DRIVE;
      S_DRIVE: if (empty_nxt) state_d = pipe_nxt ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (!empty_nxt)     state_d = S_DRIVE;
        else if (!pipe_nxt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_q     <= '0;
      q_model_q <= 1'b0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      pv_q      <= '0;
      pe_q      <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
      q_model_q <= q_model_d;
      j_q       <= j_d;
      k_q       <= k_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      pv_q      <= pv_d;
      pe_q      <= pe_d;
    end
  end

  assign tgt_ready   = !full;
  assign j           = j_q;
  assign k           = k_q;
  assign drive_valid = dv_q;
  assign err         = err_q;
  assign err_count   = cnt_q;
  assign busy        = (state_q != S_IDLE);

endmodule
